// File: rtl/jtpang_obj_pkg.sv
// jtpang_obj_pkg
// Shared constants and types for the object line buffer.
//   OBJ_AW     : default line address width (2^OBJ_AW pixels per bank)
//   OBJ_BLANK  : erase / blanking pixel value
//   OBJ_TRANSP : colour nibble that marks a transparent pixel
//   obj_state_t: line buffer controller states
package jtpang_obj_pkg;

  localparam int         OBJ_AW     = 9;
  localparam logic [7:0] OBJ_BLANK  = 8'hff;
  localparam logic [3:0] OBJ_TRANSP = 4'hf;

  typedef enum logic {
    INIT,
    RUN
  } obj_state_t;

  // A pixel is drawn only when its colour nibble is not the transparent code.
  function automatic logic obj_opaque(input logic [7:0] pxl);
    return pxl[3:0] != OBJ_TRANSP;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// jtframe_dual_ram
// Simple dual-port RAM, one clock. Port 0 is write-only, port 1 reads
// (registered, old data on a same-cycle write) and writes.
//   clk   : clock
//   data0 : port 0 write data     addr0 : port 0 address   we0 : port 0 write enable
//   data1 : port 1 write data     addr1 : port 1 address   we1 : port 1 write enable
//   q1    : port 1 registered read data
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  input  logic [dw-1:0] data1,
  input  logic [aw-1:0] addr1,
  input  logic          we1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  // Port 0 is written last so a drawer write beats a same-address erase;
  // that can only happen right after a bank swap, when the freshly drawn
  // pixel belongs to the new line and must survive.
  always_ff @(posedge clk) begin
    q1 <= mem[addr1];
    if (we1) mem[addr1] <= data1;
    if (we0) mem[addr0] <= data0;
  end

endmodule

// File: rtl/jtpang_obj_linebuf.sv
// jtpang_obj_linebuf
// Double-buffered object line buffer. The drawer fills one bank while the
// other is scanned out at pixel rate; each scanned pixel is erased right
// after being read. Banks swap on every falling edge of LHBL.
//   clk        : system clock
//   rst_n      : synchronous active-low reset (restarts the RAM clear)
//   pxl_cen    : pixel clock enable (pulses at least 2 clk apart)
//   LHBL       : horizontal blank, active low
//   hdump      : scan-out column
//   draw_we    : drawer write strobe
//   draw_addr  : drawer column
//   draw_pxl   : drawer pixel {palette, colour}
//   draw_start : one-cycle pulse when a new line may be drawn
//   init_busy  : high while the post-reset clear runs
//   obj_pxl    : pixel to the colour mixer
module jtpang_obj_linebuf
  import jtpang_obj_pkg::*;
#(
  parameter int         AW    = OBJ_AW,
  parameter logic [7:0] BLANK = OBJ_BLANK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic          draw_we,
  input  logic [AW-1:0] draw_addr,
  input  logic [7:0]    draw_pxl,
  output logic          draw_start,
  output logic          init_busy,
  output logic [7:0]    obj_pxl
);

  obj_state_t  state_reg;
  logic [AW:0] clr_a_reg;
  logic        scan_bank_reg;
  logic        erase_pend_reg;
  logic [AW:0] erase_addr_reg;
  logic        rd_valid_reg;
  logic        lhbl_l_reg;
  logic        draw_start_reg;
  logic        init_busy_reg;
  logic [7:0]  obj_pxl_reg;

  logic        lhbl_fall;
  logic        rd_start;
  logic        we_a;
  logic [AW:0] addr_a;
  logic        we_b;
  logic [AW:0] addr_b;
  logic [7:0]  data_b;
  logic [7:0]  q_b;

  assign lhbl_fall = lhbl_l_reg & ~LHBL;
  // A pending erase owns port B; pxl_cen spacing keeps the read free then.
  assign rd_start  = (state_reg == RUN) && pxl_cen && !erase_pend_reg;

  // Draw side always targets the bank not being scanned.
  assign addr_a = {~scan_bank_reg, draw_addr};
  assign we_a   = (state_reg == RUN) && draw_we && obj_opaque(draw_pxl);

  // Port B: clear counter during INIT, otherwise erase or scan read.
  always_comb begin
    addr_b = clr_a_reg;
    we_b   = 1'b0;
    data_b = BLANK;
    if (state_reg == INIT) begin
      we_b = 1'b1;
    end else if (erase_pend_reg) begin
      addr_b = erase_addr_reg;
      we_b   = 1'b1;
    end else begin
      addr_b = {scan_bank_reg, hdump};
    end
  end

  jtframe_dual_ram #(
    .dw (8),
    .aw (AW+1)
  ) u_ram (
    .clk   (clk),
    .data0 (draw_pxl),
    .addr0 (addr_a),
    .we0   (we_a),
    .data1 (data_b),
    .addr1 (addr_b),
    .we1   (we_b),
    .q1    (q_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= INIT;
      clr_a_reg      <= '0;
      scan_bank_reg  <= 1'b0;
      erase_pend_reg <= 1'b0;
      erase_addr_reg <= '0;
      rd_valid_reg   <= 1'b0;
      lhbl_l_reg     <= 1'b0;
      draw_start_reg <= 1'b0;
      init_busy_reg  <= 1'b1;
      obj_pxl_reg    <= BLANK;
    end else begin
      lhbl_l_reg     <= LHBL;
      draw_start_reg <= 1'b0;
      case (state_reg)
        INIT: begin
          clr_a_reg    <= clr_a_reg + 1'b1;
          obj_pxl_reg  <= BLANK;
          rd_valid_reg <= 1'b0;
          if (clr_a_reg == '1) begin
            state_reg     <= RUN;
            init_busy_reg <= 1'b0;
          end
        end
        RUN: begin
          if (lhbl_fall) begin
            scan_bank_reg  <= ~scan_bank_reg;
            draw_start_reg <= 1'b1;
          end
          if (erase_pend_reg) begin
            erase_pend_reg <= 1'b0;
          end else if (rd_start) begin
            erase_pend_reg <= 1'b1;
            erase_addr_reg <= addr_b;
          end
          rd_valid_reg <= rd_start;
          // RAM data is valid the cycle after the read was issued.
          if (!LHBL)
            obj_pxl_reg <= BLANK;
          else if (rd_valid_reg)
            obj_pxl_reg <= q_b;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  assign draw_start = draw_start_reg;
  assign init_busy  = init_busy_reg;
  assign obj_pxl    = obj_pxl_reg;

endmodule

// File: doc/jtpang_obj_linebuf.md
# jtpang_obj_linebuf

Double-buffered object line buffer feeding the colour mixer's `obj_pxl` input. The object drawer writes the pixels of the next scan line into one bank while the other bank is read out at pixel rate. Each scanned pixel is erased back to transparent right after it is read. Banks swap at the start of every horizontal blank.

## Interface
Parameters:
- `AW`, 9, line address width; each bank holds 2^AW pixels.
- `BLANK`, 8'hff, erase and blank value; its low nibble 4'hf marks a transparent pixel.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pxl_cen`  in  1  pixel clock enable; at most one pulse every 2 `clk` cycles.
- `LHBL`  in  1  horizontal blank, active low.
- `hdump`  in  AW  current scan-out column.
- `draw_we`  in  1  drawer write strobe.
- `draw_addr`  in  AW  drawer column.
- `draw_pxl`  in  8  drawer pixel: {palette[7:4], colour[3:0]}.
- `draw_start`  out  1  one-cycle pulse; a new line may be drawn.
- `init_busy`  out  1  high while the post-reset clear is running.
- `obj_pxl`  out  8  pixel sent to the colour mixer.

## Operation
Memory:
- One dual-port RAM of 2^(AW+1) x 8.
- Address MSB is the bank bit.
- Port A is the draw side; it only writes.
- Port B is the scan side; it reads, then erases.

FSM with two states, INIT and RUN.

INIT, entered on reset:
- A counter `clr_a` runs 0 to 2^(AW+1)-1.
- One `BLANK` is written per `clk` through port B.
- `init_busy`=1 and `obj_pxl`=`BLANK` throughout.
- Draw writes are ignored.
- After the final address, move to RUN on the next cycle and set `init_busy`=0.

RUN:
- Draw write:
  - Happens when `draw_we` is high and `draw_pxl[3:0]`!=4'hf.
  - Writes address {~`scan_bank`, `draw_addr`}.
  - Transparent writes are discarded, so the underlying pixel shows through.
  - When two writes hit one column, the later one wins.
- Scan read:
  - On `pxl_cen`, read address {`scan_bank`, `hdump`}.
  - Raise `erase_pend`.
- Erase:
  - On the cycle after the read, write `BLANK` to the same address through port B.
  - Clear `erase_pend` on that cycle.
- Bank swap:
  - The falling edge of `LHBL` is detected from a registered copy.
  - The edge toggles `scan_bank` on the next `clk`.
  - `draw_start` pulses on the same cycle as the toggle.
  - Any draw write that arrives before the toggle cycle goes to the old draw bank.
- Blanking: while `LHBL`=0, `obj_pxl` is forced to `BLANK`. Reads and erases continue.

## Timing
- Reset values:
  - `obj_pxl`=8'hff
  - `draw_start`=0
  - `init_busy`=1
  - `scan_bank`=0
  - state INIT, `clr_a`=0, `erase_pend`=0
- `rst_n` low during RUN or INIT: the clear restarts at address 0 on the next cycle.
- Scan latency, with the `pxl_cen` cycle as N:
  - Address presented in cycle N.
  - RAM output available in N+1.
  - `obj_pxl` registered at the end of N+1.
  - `obj_pxl` is valid from N+2 and holds until the next update.
- Erase occurs in cycle N+1. It must not conflict with the read, because `pxl_cen` spacing is at least 2.
- Swap:
  - `LHBL` falls in cycle M; the registered copy sees it in M+1.
  - Toggle and `draw_start` occur in M+1.
- Draw write lands one `clk` after `draw_we`; the drawer has no back-pressure.
- INIT length is exactly 2^(AW+1) cycles. For `AW`=9 that is 1024, and `init_busy` falls in cycle 1024 after reset release.
- `hdump` wrap at 2^AW-1 to 0 needs no special handling.

## Structure
- Package `jtpang_obj_pkg`:
  - `OBJ_AW`=9
  - `OBJ_BLANK`=8'hff
  - `OBJ_TRANSP`=4'hf
  - FSM state enum {INIT, RUN}
- Sub-module: the existing `jtframe_dual_ram` (`aw`=`AW`+1) as the line storage.
- Port B address and data are muxed between the clear counter, scan read and erase.

## Test plan
1. Reset, then hold `rst_n`=1:
   - `init_busy` stays 1 for 1024 cycles.
   - All RAM words are 8'hff afterwards.
   - `obj_pxl`=8'hff throughout.
2. Draw and swap:
   - Draw `draw_addr`=5, `draw_pxl`=8'h23 into the draw bank.
   - Drop `LHBL` and observe `draw_start` after 1 cycle.
   - Raise `LHBL` and scan `hdump`=5.
   - Expect `obj_pxl`=8'h23 at N+2.
3. Transparency:
   - Draw 8'h23 then 8'h4f at the same address.
   - Expect the scan to return 8'h23.
   - Draw 8'h23 then 8'h41; expect 8'h41.
4. Erase-after-read:
   - Scan address 5 on one line.
   - Two swaps later, scan address 5 again with no new draw.
   - Expect 8'hff.
5. Blanking and simultaneous events:
   - `draw_we` in the same cycle `LHBL` falls: the pixel appears on the line being swapped in.
   - `obj_pxl`=8'hff while `LHBL`=0, even when the bank holds data.
6. Reset mid-line:
   - Assert `rst_n`=0 for 1 cycle while scanning.
   - Expect `obj_pxl`=8'hff next cycle, `init_busy`=1, and the full clear to rerun.
